memory_responder: RTL and testbench

Memory-side responder for the CPU's MFA/MFC memory handshake. It owns a byte-addressed RAM and serves word and byte reads and writes requested by the control unit, with a configurable wait latency. Address comes from the MAR and write data from the MBR; read data returns to the MBR. It completes the four-phase protocol: MFA rise, then MFC rise, then MFA fall, then MFC fall.

---
 rtl/memory_responder_if.sv | 26 ++
 rtl/memory_responder.sv | 123 ++++++++++++
 tb/tb_memory_responder.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/memory_responder_if.sv
// MFA/MFC memory handshake bundle between the
// control unit (master) and the memory responder (slave).
interface memory_responder_if #(
    parameter int ADDR_WIDTH = 8
);
    logic                  MFA;
    logic                  READ_WRITE;
    logic                  WORD_BYTE;
    logic [ADDR_WIDTH-1:0] Address;
    logic [31:0]           DataIn;
    logic                  MFC;
    logic [31:0]           DataOut;
    logic                  Busy;

    modport master (
        output MFA, READ_WRITE, WORD_BYTE,
        output Address, DataIn,
        input  MFC, DataOut, Busy
    );

    modport slave (
        input  MFA, READ_WRITE, WORD_BYTE,
        input  Address, DataIn,
        output MFC, DataOut, Busy
    );
endinterface

// File: rtl/memory_responder.sv
// Byte-addressed RAM answering the four-phase MFA/MFC
// handshake with big-endian aligned word and byte access.
module memory_responder #(
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic            Clk,
    input  logic            Reset,
    memory_responder_if.slave bus
);
    localparam int         DEPTH   = 1 << ADDR_WIDTH;
    localparam logic [3:0] LP_WAIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t                r_state;
    logic [3:0]            r_cnt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_wdata;
    logic                  r_rd;
    logic                  r_word;
    logic                  r_mfc;
    logic                  r_busy;
    logic [31:0]           r_dout;
    logic [7:0]            r_mem [0:DEPTH-1];

    logic [ADDR_WIDTH-1:0] w_a0;
    logic [ADDR_WIDTH-1:0] w_a1;
    logic [ADDR_WIDTH-1:0] w_a2;
    logic [ADDR_WIDTH-1:0] w_a3;
    logic                  w_fire;
    logic                  w_we;
    logic [31:0]           w_rdata;

    assign w_a0 = {r_addr[ADDR_WIDTH-1:2], 2'b00};
    assign w_a1 = {r_addr[ADDR_WIDTH-1:2], 2'b01};
    assign w_a2 = {r_addr[ADDR_WIDTH-1:2], 2'b10};
    assign w_a3 = {r_addr[ADDR_WIDTH-1:2], 2'b11};

    // The access commits only on the BUSY->DONE edge.
    assign w_fire = (r_state == BUSY) && bus.MFA
                    && (r_cnt == 4'd0);
    assign w_we   = w_fire && !r_rd && !Reset;

    assign w_rdata = r_word
        ? {r_mem[w_a0], r_mem[w_a1],
           r_mem[w_a2], r_mem[w_a3]}
        : {24'h0, r_mem[r_addr]};

    always_ff @(posedge Clk) begin
        if (w_we) begin
            if (r_word) begin
                r_mem[w_a0] <= r_wdata[31:24];
                r_mem[w_a1] <= r_wdata[23:16];
                r_mem[w_a2] <= r_wdata[15:8];
                r_mem[w_a3] <= r_wdata[7:0];
            end else begin
                r_mem[r_addr] <= r_wdata[7:0];
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_addr  <= '0;
            r_wdata <= 32'h0;
            r_rd    <= 1'b0;
            r_word  <= 1'b0;
            r_mfc   <= 1'b0;
            r_busy  <= 1'b0;
            r_dout  <= 32'h0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (bus.MFA) begin
                        r_addr  <= bus.Address;
                        r_wdata <= bus.DataIn;
                        r_rd    <= bus.READ_WRITE;
                        r_word  <= bus.WORD_BYTE;
                        r_cnt   <= LP_WAIT;
                        r_busy  <= 1'b1;
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    if (!bus.MFA) begin
                        r_cnt   <= 4'd0;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else if (r_cnt == 4'd0) begin
                        r_mfc   <= 1'b1;
                        r_state <= DONE;
                        if (r_rd) begin
                            r_dout <= w_rdata;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                DONE: begin
                    if (!bus.MFA) begin
                        r_mfc   <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.MFC     = r_mfc;
    assign bus.Busy    = r_busy;
    assign bus.DataOut = r_dout;
endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder: one instance with
// WAIT_CYCLES=2 (sel 1) and one with WAIT_CYCLES=0 (sel 0).
module tb_memory_responder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tot = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    memory_responder_if #(.ADDR_WIDTH(8)) if2 ();
    memory_responder_if #(.ADDR_WIDTH(8)) if0 ();

    memory_responder #(
        .ADDR_WIDTH (8),
        .WAIT_CYCLES(2)
    ) u_dut2 (
        .Clk  (clk),
        .Reset(rst),
        .bus  (if2.slave)
    );

    memory_responder #(
        .ADDR_WIDTH (8),
        .WAIT_CYCLES(0)
    ) u_dut0 (
        .Clk  (clk),
        .Reset(rst),
        .bus  (if0.slave)
    );

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tot++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h",
                     tag, obs, exp);
        end
    endtask

    task automatic drive(input int sel,
                         input logic mfa,
                         input logic rw,
                         input logic wb,
                         input logic [7:0] a,
                         input logic [31:0] d);
        if (sel == 1) begin
            if2.MFA = mfa; if2.READ_WRITE = rw;
            if2.WORD_BYTE = wb; if2.Address = a;
            if2.DataIn = d;
        end else begin
            if0.MFA = mfa; if0.READ_WRITE = rw;
            if0.WORD_BYTE = wb; if0.Address = a;
            if0.DataIn = d;
        end
    endtask

    function automatic logic g_mfc(input int sel);
        return (sel == 1) ? if2.MFC : if0.MFC;
    endfunction

    function automatic logic g_busy(input int sel);
        return (sel == 1) ? if2.Busy : if0.Busy;
    endfunction

    function automatic logic [31:0] g_dout(input int sel);
        return (sel == 1) ? if2.DataOut : if0.DataOut;
    endfunction

    // Full handshake; lat is the instance's WAIT_CYCLES.
    task automatic acc(input int sel,
                       input logic rw,
                       input logic wb,
                       input logic [7:0] a,
                       input logic [31:0] d,
                       input int lat,
                       input int hold,
                       input string tag,
                       output logic [31:0] q);
        int n;
        @(negedge clk);
        drive(sel, 1'b1, rw, wb, a, d);
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!g_mfc(sel) && n < 40);
        chk({tag, "_lat"}, 32'(n - 1), 32'(lat + 1));
        q = g_dout(sel);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            drive(sel, 1'b1, rw, wb, a + 8'd1, ~d);
            @(posedge clk); #1;
            chk({tag, "_hold"}, 32'(g_mfc(sel)), 32'd1);
        end
        @(negedge clk);
        drive(sel, 1'b0, rw, wb, a, d);
        @(posedge clk); #1;
        chk({tag, "_rel"}, 32'(g_mfc(sel)), 32'd0);
        chk({tag, "_idle"}, 32'(g_busy(sel)), 32'd0);
    endtask

    initial begin
        logic [31:0] q;
        logic        seen;
        int          n;
        drive(1, 1'b0, 1'b0, 1'b0, 8'h0, 32'h0);
        drive(0, 1'b0, 1'b0, 1'b0, 8'h0, 32'h0);
        #2;
        chk("rst_mfc", 32'(if2.MFC), 32'd0);
        chk("rst_busy", 32'(if2.Busy), 32'd0);
        chk("rst_dout", if2.DataOut, 32'h0);
        chk("rst_dout0", if0.DataOut, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        acc(1, 1'b0, 1'b1, 8'h10, 32'hDEADBEEF,
            2, 0, "wr10", q);
        acc(1, 1'b1, 1'b1, 8'h12, 32'h0,
            2, 0, "rd12", q);
        chk("rd12_data", q, 32'hDEADBEEF);

        acc(1, 1'b0, 1'b0, 8'h11, 32'h777777A5,
            2, 0, "wb11", q);
        acc(1, 1'b1, 1'b1, 8'h10, 32'h0,
            2, 0, "rdw10", q);
        chk("rdw10_data", q, 32'hDEA5BEEF);
        acc(1, 1'b1, 1'b0, 8'h11, 32'h0,
            2, 0, "rdb11", q);
        chk("rdb11_data", q, 32'h000000A5);

        acc(1, 1'b0, 1'b1, 8'h30, 32'h11223344,
            2, 10, "hold", q);
        acc(1, 1'b1, 1'b1, 8'h30, 32'h0,
            2, 0, "rd30", q);
        chk("rd30_data", q, 32'h11223344);

        acc(1, 1'b0, 1'b1, 8'h20, 32'hCAFEF00D,
            2, 0, "wr20", q);
        acc(1, 1'b1, 1'b1, 8'h20, 32'h0,
            2, 0, "rd20", q);
        chk("rd20_data", q, 32'hCAFEF00D);

        @(negedge clk);
        drive(1, 1'b1, 1'b0, 1'b1, 8'h20, 32'h12345678);
        @(posedge clk); #1;
        chk("abt_busy", 32'(if2.Busy), 32'd1);
        @(negedge clk);
        drive(1, 1'b0, 1'b0, 1'b1, 8'h20, 32'h12345678);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            seen = seen | if2.MFC;
        end
        chk("abt_mfc", 32'(seen), 32'd0);
        chk("abt_idle", 32'(if2.Busy), 32'd0);
        chk("abt_dout", if2.DataOut, 32'hCAFEF00D);
        acc(1, 1'b1, 1'b1, 8'h20, 32'h0,
            2, 0, "abt_rd", q);
        chk("abt_rd_data", q, 32'hCAFEF00D);

        @(negedge clk);
        drive(1, 1'b1, 1'b0, 1'b1, 8'h20, 32'h55555555);
        @(posedge clk); #1;
        chk("rb_busy1", 32'(if2.Busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rb_mfc", 32'(if2.MFC), 32'd0);
        chk("rb_busy", 32'(if2.Busy), 32'd0);
        chk("rb_dout", if2.DataOut, 32'h0);
        @(negedge clk);
        drive(1, 1'b0, 1'b0, 1'b1, 8'h20, 32'h0);
        rst = 1'b0;
        acc(1, 1'b1, 1'b1, 8'h20, 32'h0,
            2, 0, "rb_rd", q);
        chk("rb_rd_data", q, 32'hCAFEF00D);

        @(negedge clk);
        drive(1, 1'b1, 1'b1, 1'b1, 8'h10, 32'h0);
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!if2.MFC && n < 40);
        chk("rd_mfc_up", 32'(if2.MFC), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rd_mfc_rst", 32'(if2.MFC), 32'd0);
        @(negedge clk);
        drive(1, 1'b0, 1'b1, 1'b1, 8'h10, 32'h0);
        rst = 1'b0;

        acc(0, 1'b1, 1'b0, 8'h41, 32'h0,
            0, 0, "z_rd0", q);
        acc(0, 1'b0, 1'b1, 8'h40, 32'h0A0B0C0D,
            0, 0, "z_wr", q);
        acc(0, 1'b1, 1'b1, 8'h42, 32'h0,
            0, 0, "z_rd1", q);
        chk("z_rd1_data", q, 32'h0A0B0C0D);
        acc(0, 1'b0, 1'b0, 8'h43, 32'h000000EE,
            0, 0, "z_wb", q);
        acc(0, 1'b1, 1'b1, 8'h40, 32'h0,
            0, 0, "z_rd2", q);
        chk("z_rd2_data", q, 32'h0A0B0CEE);
        acc(0, 1'b1, 1'b0, 8'h41, 32'h0,
            0, 0, "z_rdb", q);
        chk("z_rdb_data", q, 32'h0000000B);

        $display("test done: total=%0d bad=%0d",
                 n_tot, n_bad);
        $finish;
    end
endmodule
